// File: rtl/mem_stage_if.sv
// Data-SRAM request/response bus between the MEM stage (master) and the data memory (slave).
// Uses a req/addr_ok handshake for requests and data_ok for responses.
interface mem_stage_if #(
    parameter int ADDR_W = 32
);
    logic              data_sram_req;
    logic              data_sram_wr;
    logic [3:0]        data_sram_wstrb;
    logic [ADDR_W-1:0] data_sram_addr;
    logic [31:0]       data_sram_wdata;
    logic              data_sram_addr_ok;
    logic              data_sram_data_ok;
    logic [31:0]       data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-SRAM loads/stores, forwards results to WB and the bypass unit.
// Optional stall counter on mem_stall_cnt is built when MEM_STALL_CNT_EN is defined.
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         EX_to_MEM_valid,
    output logic         MEM_allow_in,
    input  logic [107:0] EX_to_MEM_bus,
    output logic         MEM_to_WB_valid,
    input  logic         WB_allow_in,
    output logic [110:0] MEM_to_WB_bus,
    output logic [39:0]  MEM_to_BY_bus,
    mem_stage_if.master  data_sram,
    output logic [31:0]  mem_stall_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_valid;
    logic [107:0]  r_ex_bus;
    logic [31:0]   r_rdata;

    logic [2:0]    w_stage_valid;
    logic          w_rf_w_en;
    logic          w_is_load;
    logic          w_is_byte;
    logic          w_is_store;
    logic [4:0]    w_rf_w_addr;
    logic [31:0]   w_alu_result;
    logic [31:0]   w_store_data;
    logic [31:0]   w_inst_pc;

    logic          w_mem_op;
    logic          w_new_mem_op;
    logic          w_ready_go;
    logic          w_accept;
    logic [3:0]    w_lane;
    logic [3:0]    w_b_en;
    logic [31:0]   w_r_data;
    logic          w_data_valid;

    assign {w_stage_valid, w_rf_w_en, w_is_load, w_is_byte, w_is_store,
            w_rf_w_addr, w_alu_result, w_store_data, w_inst_pc} = r_ex_bus;

    assign w_mem_op        = w_is_load | w_is_store;
    assign w_new_mem_op    = EX_to_MEM_bus[103] | EX_to_MEM_bus[101];
    assign w_ready_go      = ~w_mem_op | (r_state == S_DONE);
    assign MEM_allow_in    = ~r_valid | (w_ready_go & WB_allow_in);
    assign MEM_to_WB_valid = r_valid & w_ready_go;
    assign w_accept        = EX_to_MEM_valid & MEM_allow_in;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_ex_bus <= '0;
            r_rdata  <= '0;
        end else begin
            if (MEM_allow_in) r_valid <= EX_to_MEM_valid;
            if (w_accept) r_ex_bus <= EX_to_MEM_bus;
            if (r_state == S_WAIT && data_sram.data_sram_data_ok && w_is_load)
                r_rdata <= data_sram.data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // A newly accepted instruction always decides the next state; data_ok outside S_WAIT is ignored.
    always_comb begin
        // NOTE: default first so no path through the case leaves w_next_state unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            S_REQ:   if (data_sram.data_sram_addr_ok) w_next_state = S_WAIT;
            S_WAIT:  if (data_sram.data_sram_data_ok) w_next_state = S_DONE;
            S_DONE:  if (MEM_to_WB_valid & WB_allow_in) w_next_state = S_IDLE;
            default: w_next_state = r_state;
        endcase
        if (w_accept) w_next_state = w_new_mem_op ? S_REQ : S_IDLE;
    end

    assign w_lane       = 4'b0001 << w_alu_result[1:0];
    assign w_b_en       = w_is_byte ? w_lane : 4'hF;
    assign w_r_data     = w_is_load ? r_rdata : 32'd0;
    assign w_data_valid = r_valid & ~w_is_load & (w_stage_valid[0] | w_stage_valid[1]);

    // Request fields come straight from the held instruction, so they stay stable while addr_ok is low.
    assign data_sram.data_sram_req   = (r_state == S_REQ);
    assign data_sram.data_sram_wr    = w_is_store;
    assign data_sram.data_sram_wstrb = w_is_store ? w_b_en : 4'h0;
    assign data_sram.data_sram_addr  = {w_alu_result[ADDR_W-1:2], 2'b00};
    assign data_sram.data_sram_wdata = ~w_is_store ? 32'd0
                                     : (w_is_byte ? {4{w_store_data[7:0]}} : w_store_data);

    assign MEM_to_WB_bus = {w_stage_valid, w_rf_w_en, w_is_load, w_is_byte, w_b_en,
                            w_r_data, w_rf_w_addr, w_alu_result, w_inst_pc};
    assign MEM_to_BY_bus = {w_rf_w_addr, w_alu_result, w_data_valid, r_valid, w_rf_w_en};

`ifdef MEM_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset)                          r_stall_cnt <= 32'd0;
        else if (r_valid & ~MEM_allow_in)   r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign mem_stall_cnt = r_stall_cnt;
`else
    assign mem_stall_cnt = 32'd0;
`endif

endmodule
